// File: rtl/frame_buffer_arbiter_if.sv
// frame_buffer_arbiter_if: pixel-writer handshake and SRAM port bundle.
interface frame_buffer_arbiter_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [23:0] mem_din;
  logic [23:0] mem_dout;
  modport master (output wr_valid, wr_addr, wr_data, mem_dout, input wr_ready, mem_addr, mem_we, mem_din);
  modport slave (input wr_valid, wr_addr, wr_data, mem_dout, output wr_ready, mem_addr, mem_we, mem_din);
endinterface

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: shares a single-port frame-buffer SRAM between raster scan-out reads
// (issued LEAD cycles ahead, always winning) and a FIFO-buffered pixel writer.
module frame_buffer_arbiter #(
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768,
  parameter int H_TOTAL    = 1344,
  parameter int V_TOTAL    = 806,
  parameter int LEAD       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       vclock,
  input  logic                       reset_n,
  input  logic [10:0]                hcount,
  input  logic [9:0]                 vcount,
  input  logic                       hsync,
  input  logic                       vsync,
  input  logic                       blank,
  frame_buffer_arbiter_if.slave      bus,
  output logic [23:0]                pixel,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       blank_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int HW = H_ACTIVE / 2;
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  logic [11:0] h_sum, ha, half;
  logic [9:0]  va;
  logic        wrap, rd_slot, pop, push;
  logic [18:0] rd_addr;
  logic [42:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0] count_q, count_d;
  logic [2:0]  rd_q;
  logic [23:0] pair_q;
  assign bus.wr_ready = count_q != FULL;
  always_comb begin
    h_sum   = 12'(hcount) + 12'(LEAD);
    wrap    = h_sum >= 12'(H_TOTAL);
    ha      = wrap ? h_sum - 12'(H_TOTAL) : h_sum;
    va      = !wrap ? vcount : (vcount == 10'(V_TOTAL - 1)) ? '0 : vcount + 10'd1;
    rd_slot = !ha[0] && ha < 12'(H_ACTIVE) && va < 10'(V_ACTIVE);
    rd_addr = 19'(va) * 19'(HW) + 19'(ha[11:1]);
    pop     = !rd_slot && count_q != '0;
    push    = bus.wr_valid && bus.wr_ready;
    count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    half    = hcount[0] ? pair_q[11:0] : pair_q[23:12];
  end
  always_ff @(posedge vclock)
    if (push) fifo_q[tail_q] <= {bus.wr_addr, bus.wr_data};
  // rd_q tracks each issued read through the SRAM's two-cycle pipe to its capture edge
  always_ff @(posedge vclock or negedge reset_n)
    if (!reset_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      rd_q         <= '0;
      pair_q       <= '0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      pixel        <= '0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      blank_out    <= 1'b0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop) head_q <= head_q + 1'b1;
      count_q      <= count_d;
      rd_q         <= {rd_q[1:0], rd_slot};
      if (rd_q[2]) pair_q <= bus.mem_dout;
      bus.mem_we   <= pop;
      bus.mem_addr <= rd_slot ? rd_addr : pop ? fifo_q[head_q][42:24] : '0;
      bus.mem_din  <= pop ? fifo_q[head_q][23:0] : '0;
      pixel        <= blank ? '0 : {half[11:8], half[11:8], half[7:4], half[7:4], half[3:0], half[3:0]};
      hsync_out    <= hsync;
      vsync_out    <= vsync;
      blank_out    <= blank;
    end
endmodule
